// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback and driving datapath selects, write strobes and ALU opcode.
module mips_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcEn,
  output logic       irWrite,
  output logic       memWrite,
  output logic       regWrite,
  output logic       iOrD,
  output logic       regDst,
  output logic       memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSrc,
  output logic [3:0] aluControl,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  state_t     state_q, state_d;
  logic       pc_write, branch;
  logic       ir_write_raw, mem_write_raw, reg_write_raw;
  logic [3:0] funct_alu;
  logic       funct_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // R-type funct to ALU opcode; unsupported functs fall back to ADD.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'h20:   funct_alu = 4'd0;
      6'h22:   funct_alu = 4'd1;
      6'h24:   funct_alu = 4'd2;
      6'h25:   funct_alu = 4'd3;
      6'h27:   funct_alu = 4'd4;
      6'h2A:   funct_alu = 4'd5;
      6'h00:   funct_alu = 4'd6;
      6'h02:   funct_alu = 4'd7;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = FETCH;
    pc_write      = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    iOrD          = 1'b0;
    regDst        = 1'b0;
    memToReg      = 1'b0;
    aluSrcA       = 1'b0;
    aluSrcB       = 2'b00;
    pcSrc         = 2'b00;
    aluControl    = ALU_ADD;
    case (state_q)
      FETCH: begin
        aluSrcB      = 2'b01;
        ir_write_raw = 1'b1;
        pc_write     = 1'b1;
        state_d      = DECODE;
      end
      DECODE: begin
        aluSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        iOrD    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        memToReg      = 1'b1;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        iOrD          = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECUTE: begin
        aluSrcA    = 1'b1;
        aluControl = funct_alu;
        state_d    = funct_ok ? ALUWB : FETCH;
      end
      ALUWB: begin
        regDst        = 1'b1;
        reg_write_raw = 1'b1;
      end
      BRANCH: begin
        aluSrcA    = 1'b1;
        aluControl = ALU_SUB;
        pcSrc      = 2'b01;
        branch     = 1'b1;
      end
      ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: reg_write_raw = 1'b1;
      JUMP: begin
        pcSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Strobes are gated by reset so nothing is written while it is held.
  assign pcEn     = (pc_write | (branch & zero)) & ~reset;
  assign irWrite  = ir_write_raw & ~reset;
  assign memWrite = mem_write_raw & ~reset;
  assign regWrite = reg_write_raw & ~reset;
  assign state    = state_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Randomized + directed bench for mips_control_fsm against an instruction-level
// model of state sequences and per-state control outputs.
module tb_mips_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcEn, irWrite, memWrite, regWrite, iOrD, regDst, memToReg, aluSrcA;
  logic [1:0] aluSrcB, pcSrc;
  logic [3:0] aluControl, state;

  int checks = 0;
  int failures = 0;
  int exp_seq[$];

  logic [5:0] funct_tab [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02};
  logic [5:0] op_tab [6] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};

  always #5 clk = ~clk;

  mips_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcEn(pcEn), .irWrite(irWrite), .memWrite(memWrite), .regWrite(regWrite),
    .iOrD(iOrD), .regDst(regDst), .memToReg(memToReg), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .pcSrc(pcSrc), .aluControl(aluControl), .state(state)
  );

  logic [15:0] dut_vec;
  assign dut_vec = {pcEn, irWrite, memWrite, regWrite, iOrD, regDst, memToReg,
                    aluSrcA, aluSrcB, pcSrc, aluControl};

  // ALU code of a funct is its position in the supported table, -1 if absent.
  function automatic int funct_code(logic [5:0] f);
    for (int i = 0; i < 8; i++) if (funct_tab[i] == f) return i;
    return -1;
  endfunction

  function automatic logic [15:0] exp_vec(int s, logic [5:0] f, logic z, logic r);
    logic pcw = 0, br = 0, irw = 0, mw = 0, rw = 0, iord = 0, rdst = 0, m2r = 0, asa = 0;
    logic [1:0] asb = 0, pcs = 0;
    logic [3:0] alu = 0;
    int code;
    case (s)
      0:  begin irw = 1; pcw = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; code = funct_code(f); alu = (code < 0) ? 4'd0 : 4'(code); end
      7:  begin rdst = 1; rw = 1; end
      8:  begin asa = 1; alu = 4'd1; pcs = 2'b01; br = 1; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {(pcw | (br & z)) & ~r, irw & ~r, mw & ~r, rw & ~r, iord, rdst, m2r,
            asa, asb, pcs, alu};
  endfunction

  // Expected state walk of one instruction, starting at FETCH.
  function automatic void model_seq(logic [5:0] o, logic [5:0] f);
    exp_seq = {};
    case (o)
      6'h23:   exp_seq = {0, 1, 2, 3, 4};
      6'h2B:   exp_seq = {0, 1, 2, 5};
      6'h00:   exp_seq = (funct_code(f) >= 0) ? {0, 1, 6, 7} : {0, 1, 6};
      6'h04:   exp_seq = {0, 1, 8};
      6'h08:   exp_seq = {0, 1, 9, 10};
      6'h02:   exp_seq = {0, 1, 11};
      default: exp_seq = {0, 1};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // zm: 0/1 hold zero at that value, 2 randomize it every cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zm);
    model_seq(o, f);
    op = o;
    funct = f;
    foreach (exp_seq[i]) begin
      zero = (zm == 2) ? 1'($urandom_range(1)) : zm[0];
      #1;
      chk($sformatf("state op=%h f=%h step%0d", o, f, i), {12'b0, state}, 16'(exp_seq[i]));
      chk($sformatf("outs op=%h f=%h st=%0d z=%0b", o, f, exp_seq[i], zero),
          dut_vec, exp_vec(exp_seq[i], f, zero, 1'b0));
      @(posedge clk);
      #1;
    end
    $display("instr op=%h funct=%h cycles=%0d", o, f, exp_seq.size());
  endtask

  initial begin
    reset = 1'b1;
    op = 6'h23;
    funct = 6'h00;
    zero = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset state", {12'b0, state}, 16'd0);
      chk("reset outs", dut_vec, exp_vec(0, funct, zero, 1'b1));
    end
    @(negedge clk);
    reset = 1'b0;

    run_instr(6'h23, 6'h00, 2);
    foreach (funct_tab[k]) run_instr(6'h00, funct_tab[k], 2);
    run_instr(6'h04, 6'h00, 1);
    run_instr(6'h04, 6'h00, 0);
    run_instr(6'h2B, 6'h00, 2);
    run_instr(6'h02, 6'h00, 2);
    run_instr(6'h3F, 6'h00, 2);
    run_instr(6'h00, 6'h08, 2);
    run_instr(6'h08, 6'h00, 2);

    // Abort a store mid-cycle in MEMWRITE.
    op = 6'h2B;
    zero = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
    end
    #1;
    chk("pre-abort state", {12'b0, state}, 16'd5);
    chk("pre-abort outs", dut_vec, exp_vec(5, funct, zero, 1'b0));
    #1;
    reset = 1'b1;
    #1;
    chk("abort state", {12'b0, state}, 16'd0);
    chk("abort outs", dut_vec, exp_vec(0, funct, zero, 1'b1));
    @(posedge clk);
    #1;
    chk("abort hold state", {12'b0, state}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    run_instr(6'h2B, 6'h00, 2);

    for (int n = 0; n < 300; n++) begin
      logic [5:0] o, f;
      o = ($urandom_range(9) < 7) ? op_tab[$urandom_range(5)] : 6'($urandom);
      f = ($urandom_range(9) < 7) ? funct_tab[$urandom_range(7)] : 6'($urandom);
      run_instr(o, f, 2);
    end
    #1;
    chk("final state", {12'b0, state}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
